bcd_counter_n: RTL and testbench
================================

Name: bcd_counter_n

Overview:
- Parametrised N-digit cascaded counter: the successor to the fixed 4-digit, 4-bit-per-digit counter and controller pair.
- Digit count, digit radix and overflow mode are set by parameters; all digits live in one synchronous block.
- Adds up/down counting, synchronous clear, parallel load, saturate-or-wrap mode and status flags.
- Drives the display/digit-mux stage; the enable is typically a 1 Hz tick or a debounced button strobe.

Parameters:
DIGITS, 4, number of cascaded digits (1..8)
DIG_W, 4, bits per digit
RADIX, 10, digit modulus; legal range 2..2**DIG_W
WRAP, 1, 1 = wrap at full scale; 0 = saturate and hold

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
ena  input  1  count enable, one step per clk while high
up_dn  input  1  1 = count up, 0 = count down
clr  input  1  synchronous clear to zero
load  input  1  synchronous parallel load
load_data  input  DIGITS*DIG_W  load value; digit 0 in [DIG_W-1:0]
Qdata  output  DIGITS*DIG_W  count value; digit i in [i*DIG_W +: DIG_W]
carry_out  output  1  one-cycle pulse on full-scale wrap (up or down)
sat  output  1  high while held at a limit (WRAP=0 only)
at_max  output  1  combinational: every digit == RADIX-1
at_zero  output  1  combinational: every digit == 0

Behaviour:
- Reset (rst=0, async): Qdata=0, carry_out=0, sat=0. at_zero=1 and at_max=0 follow from Qdata.
- Priority per clk edge: clr > load > ena. ena=0 with no clr/load holds Qdata and sat; carry_out=0.
- clr: Qdata=0, sat=0, carry_out=0.
- load: each digit takes min(load_data digit, RADIX-1). Out-of-range digits clamp. sat=0, carry_out=0.
- Count up (ena=1, up_dn=1):
  - digit 0 increments.
  - digit i>0 increments only when all lower digits == RADIX-1.
  - a digit at RADIX-1 that steps goes to 0.
- Count down (ena=1, up_dn=0):
  - digit 0 decrements.
  - digit i>0 decrements only when all lower digits == 0.
  - a digit at 0 that steps goes to RADIX-1.
- Carry/borrow: the full chain resolves combinationally, so all digits update on the same edge. There is no per-digit lag.
- Full-scale event: up from at_max, or down from at_zero.
  - WRAP=1: Qdata wraps to all-0 (up) or all-(RADIX-1) (down). carry_out=1 for exactly the cycle after that edge, coincident with the wrapped Qdata.
  - WRAP=0: Qdata holds, sat=1, carry_out stays 0. sat remains 1 while enabled counting continues in the same direction.
  - sat clears on clr, on load, or on a step in the opposite direction; that step is also performed on the same edge.
- up_dn may change on any cycle; it takes effect on the next enabled edge.
- carry_out is registered and is 0 on every cycle with no full-scale event, including back-to-back enabled cycles.
- Reset asserted mid-count clears all state immediately. The first enabled edge after rst deasserts counts from 0.
- Elaboration: RADIX > 2**DIG_W or RADIX < 2 raises a $error.
- All outputs are registered except at_max and at_zero.

Test Plan:
- Defaults. Reset, then ena=1 up for 10000 cycles: Qdata passes 0x0009 -> 0x0010 and 0x0999 -> 0x1000. At cycle 9999, Qdata=0x9999 and at_max=1. Next edge: Qdata=0x0000, carry_out=1 for one cycle only.
- Down from 0x1000, ena=1 up_dn=0, one step -> 0x0999. Then clr, one down step -> 0x9999 with carry_out=1.
- WRAP=0: load 0x9998, count up 3 edges -> 0x9999, then held, sat=1, carry_out never 1. Flip up_dn=0 -> next edge 0x9998, sat=0.
- Simultaneous events: clr=1, load=1, ena=1 on one edge -> 0x0000. load=1, ena=1 with load_data=0x12F4 -> 0x1294 (digit clamp; no count that edge).
- Assert rst low asynchronously between edges while counting at 0x0457: Qdata=0 immediately. Release: first enabled edge -> 0x0001.
- DIGITS=3, DIG_W=3, RADIX=6: count up from 0 for 216 edges -> returns to 0 with one carry_out pulse. Intermediate value after 7 edges -> digits {0,1,1}.

Source files
------------

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: N-digit cascaded up/down counter with configurable digit
// radix, synchronous clear, clamped parallel load and wrap-or-saturate
// behaviour at full scale. The carry/borrow chain resolves combinationally,
// so every digit updates on the same edge.
module bcd_counter_n #(
  parameter int DIGITS = 4,
  parameter int DIG_W  = 4,
  parameter int RADIX  = 10,
  parameter bit WRAP   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    up_dn,
  input  logic                    clr,
  input  logic                    load,
  input  logic [DIGITS*DIG_W-1:0] load_data,
  output logic [DIGITS*DIG_W-1:0] Qdata,
  output logic                    carry_out,
  output logic                    sat,
  output logic                    at_max,
  output logic                    at_zero
);

  // Largest legal digit value; RADIX <= 2**DIG_W keeps this within DIG_W bits.
  localparam logic [DIG_W-1:0] D_MAX = DIG_W'(RADIX - 1);

  if (RADIX < 2 || RADIX > (1 << DIG_W)) begin : g_bad_radix
    $error("bcd_counter_n: RADIX must lie in 2..2**DIG_W");
  end

  logic [DIGITS-1:0]       dig_max;
  logic [DIGITS-1:0]       dig_zero;
  logic [DIGITS*DIG_W-1:0] q_step;
  logic [DIGITS*DIG_W-1:0] q_load;
  logic                    chain;
  logic [DIG_W-1:0]        cur;
  logic [DIG_W-1:0]        ld;
  logic                    full_scale;

  // Per-digit limit flags, rippled step enables, next stepped value and the
  // clamped load value, all from the current count.
  always_comb begin
    dig_max  = '0;
    dig_zero = '0;
    q_step   = Qdata;
    q_load   = '0;
    chain    = 1'b1;
    cur      = '0;
    ld       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      cur         = Qdata[i*DIG_W +: DIG_W];
      dig_max[i]  = (cur == D_MAX);
      dig_zero[i] = (cur == '0);
      // A digit steps only when every lower digit is at its roll-over limit.
      if (chain) begin
        if (up_dn) q_step[i*DIG_W +: DIG_W] = dig_max[i]  ? '0    : cur + DIG_W'(1);
        else       q_step[i*DIG_W +: DIG_W] = dig_zero[i] ? D_MAX : cur - DIG_W'(1);
      end
      chain = chain & (up_dn ? dig_max[i] : dig_zero[i]);
      ld    = load_data[i*DIG_W +: DIG_W];
      q_load[i*DIG_W +: DIG_W] = (ld > D_MAX) ? D_MAX : ld;
    end
  end

  assign at_max     = &dig_max;
  assign at_zero    = &dig_zero;
  assign full_scale = up_dn ? at_max : at_zero;

  // Count register: clr beats load beats ena; full scale either wraps with a
  // one-cycle carry pulse or holds and flags sat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Qdata     <= '0;
      carry_out <= 1'b0;
      sat       <= 1'b0;
    end else if (clr) begin
      Qdata     <= '0;
      carry_out <= 1'b0;
      sat       <= 1'b0;
    end else if (load) begin
      Qdata     <= q_load;
      carry_out <= 1'b0;
      sat       <= 1'b0;
    end else if (ena) begin
      if (full_scale && !WRAP) begin
        carry_out <= 1'b0;
        sat       <= 1'b1;
      end else begin
        // Stepping from full scale in this branch is the wrap itself.
        Qdata     <= q_step;
        carry_out <= full_scale;
        sat       <= 1'b0;
      end
    end else begin
      carry_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: three instances (default wrap, saturating, and a
// 3-digit radix-6 variant) checked against an integer-valued model.
module tb_bcd_counter_n;

  localparam int W = 34;  // {carry_out, sat, Qdata zero-extended to 32}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: defaults (4 digits, radix 10, wrap)
  logic        a_ena, a_up_dn, a_clr, a_load;
  logic [15:0] a_load_data, a_q;
  logic        a_carry, a_sat, a_max, a_zero;
  // Instance B: saturating
  logic        b_ena, b_up_dn, b_clr, b_load;
  logic [15:0] b_load_data, b_q;
  logic        b_carry, b_sat, b_max, b_zero;
  // Instance C: 3 digits, 3 bits, radix 6
  logic        c_ena, c_up_dn, c_clr, c_load;
  logic [8:0]  c_load_data, c_q;
  logic        c_carry, c_sat, c_max, c_zero;

  bcd_counter_n u_a (
    .clk(clk), .rst(rst), .ena(a_ena), .up_dn(a_up_dn), .clr(a_clr), .load(a_load),
    .load_data(a_load_data), .Qdata(a_q), .carry_out(a_carry), .sat(a_sat),
    .at_max(a_max), .at_zero(a_zero));

  bcd_counter_n #(.WRAP(1'b0)) u_b (
    .clk(clk), .rst(rst), .ena(b_ena), .up_dn(b_up_dn), .clr(b_clr), .load(b_load),
    .load_data(b_load_data), .Qdata(b_q), .carry_out(b_carry), .sat(b_sat),
    .at_max(b_max), .at_zero(b_zero));

  bcd_counter_n #(.DIGITS(3), .DIG_W(3), .RADIX(6)) u_c (
    .clk(clk), .rst(rst), .ena(c_ena), .up_dn(c_up_dn), .clr(c_clr), .load(c_load),
    .load_data(c_load_data), .Qdata(c_q), .carry_out(c_carry), .sat(c_sat),
    .at_max(c_max), .at_zero(c_zero));

  // Scoreboard and counters
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Model state and per-instance configuration
  int r_of[3]    = '{10, 10, 6};
  int d_of[3]    = '{4, 4, 3};
  int w_of[3]    = '{4, 4, 3};
  bit wrap_of[3] = '{1'b1, 1'b0, 1'b1};
  int m_cnt[3]   = '{0, 0, 0};
  bit m_sat[3]   = '{1'b0, 1'b0, 1'b0};
  int carries;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] to_q(input int v, input int r, input int d, input int w);
    logic [31:0] q;
    q = '0;
    for (int i = 0; i < d; i++) begin
      q = q | (32'(v % r) << (i * w));
      v = v / r;
    end
    return q;
  endfunction

  function automatic int load_val(input logic [31:0] ld, input int r, input int d, input int w);
    int v, mul, dig;
    v = 0;
    mul = 1;
    for (int i = 0; i < d; i++) begin
      dig = int'((ld >> (i * w)) & ((32'd1 << w) - 32'd1));
      if (dig > r - 1) dig = r - 1;
      v += dig * mul;
      mul *= r;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] observe(input int sel);
    case (sel)
      0:       return {a_carry, a_sat, 16'h0, a_q};
      1:       return {b_carry, b_sat, 16'h0, b_q};
      default: return {c_carry, c_sat, 23'h0, c_q};
    endcase
  endfunction

  function automatic logic [1:0] observe_flags(input int sel);
    case (sel)
      0:       return {a_max, a_zero};
      1:       return {b_max, b_zero};
      default: return {c_max, c_zero};
    endcase
  endfunction

  function automatic logic [W-1:0] model_word(input int sel, input bit co);
    return {co, m_sat[sel], to_q(m_cnt[sel], r_of[sel], d_of[sel], w_of[sel])};
  endfunction

  // Numeric model of one clock edge.
  task automatic model_step(input int sel, input bit c, input bit l, input logic [31:0] ld,
                            input bit e, input bit u, output bit co);
    int full;
    full = r_of[sel] ** d_of[sel];
    co = 1'b0;
    if (c) begin
      m_cnt[sel] = 0; m_sat[sel] = 1'b0;
    end else if (l) begin
      m_cnt[sel] = load_val(ld, r_of[sel], d_of[sel], w_of[sel]); m_sat[sel] = 1'b0;
    end else if (e) begin
      if (u && m_cnt[sel] == full - 1) begin
        if (wrap_of[sel]) begin m_cnt[sel] = 0; co = 1'b1; end
        else m_sat[sel] = 1'b1;
      end else if (!u && m_cnt[sel] == 0) begin
        if (wrap_of[sel]) begin m_cnt[sel] = full - 1; co = 1'b1; end
        else m_sat[sel] = 1'b1;
      end else begin
        m_cnt[sel] = u ? m_cnt[sel] + 1 : m_cnt[sel] - 1;
        m_sat[sel] = 1'b0;
      end
    end
  endtask

  task automatic set_inputs(input int sel, input bit c, input bit l, input logic [31:0] ld,
                            input bit e, input bit u);
    case (sel)
      0: begin a_clr = c; a_load = l; a_load_data = ld[15:0]; a_ena = e; a_up_dn = u; end
      1: begin b_clr = c; b_load = l; b_load_data = ld[15:0]; b_ena = e; b_up_dn = u; end
      default: begin c_clr = c; c_load = l; c_load_data = ld[8:0]; c_ena = e; c_up_dn = u; end
    endcase
  endtask

  // Drive one edge on one instance, push the expected result, then pop and
  // compare once the registered outputs have settled.
  task automatic drive(input int sel, input bit c, input bit l, input logic [31:0] ld,
                       input bit e, input bit u, input string tag);
    bit co;
    int full;
    logic [W-1:0] exp_w;
    set_inputs(sel, c, l, ld, e, u);
    model_step(sel, c, l, ld, e, u, co);
    exp_q.push_back(model_word(sel, co));
    @(posedge clk);
    #1;
    exp_w = exp_q.pop_front();
    check({tag, "_out"}, 64'(observe(sel)), 64'(exp_w));
    full = r_of[sel] ** d_of[sel];
    check({tag, "_flags"}, 64'(observe_flags(sel)),
          64'({(m_cnt[sel] == full - 1), (m_cnt[sel] == 0)}));
    if (exp_w[W-1]) carries++;
    set_inputs(sel, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b0;
    for (int s = 0; s < 3; s++) set_inputs(s, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    carries = 0;

    // Reset state
    @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check("reset_out", 64'(observe(s)), 64'(0));
      check("reset_flags", 64'(observe_flags(s)), 64'(2'b01));
    end
    rst = 1'b1;

    // Full 10000-step up count on the default instance
    for (int i = 0; i < 10000; i++) begin
      drive(0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, "a_up");
      if (i == 9)    check("a_0010", 64'(a_q), 64'h0010);
      if (i == 999)  check("a_1000", 64'(a_q), 64'h1000);
      if (i == 9998) check("a_9999_max", 64'({a_max, a_q}), 64'h1_9999);
      if (i == 9999) check("a_wrap", 64'({a_carry, a_q}), 64'h1_0000);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, "a_after_wrap");
    check("a_carry_one_cycle", 64'(a_carry), 64'(0));

    // Down from 0x1000, then borrow out of zero
    drive(0, 1'b0, 1'b1, 32'h1000, 1'b0, 1'b1, "a_load1000");
    drive(0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "a_down");
    check("a_0999", 64'(a_q), 64'h0999);
    drive(0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "a_clr");
    drive(0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "a_borrow");
    check("a_borrow_9999", 64'({a_carry, a_q}), 64'h1_9999);

    // Saturating instance
    drive(1, 1'b0, 1'b1, 32'h9998, 1'b0, 1'b1, "b_load");
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, "b_up");
      check("b_no_carry", 64'(b_carry), 64'(0));
    end
    check("b_held", 64'({b_sat, b_q}), 64'h1_9999);
    drive(1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "b_reverse");
    check("b_released", 64'({b_sat, b_q}), 64'h0_9998);
    drive(1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "b_clr");
    drive(1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "b_sat_low");
    drive(1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "b_sat_low2");
    check("b_low_held", 64'({b_sat, b_carry, b_q}), 64'h2_0000);

    // Priority and digit clamp
    drive(0, 1'b0, 1'b1, 32'h5555, 1'b0, 1'b1, "a_pre");
    drive(0, 1'b1, 1'b1, 32'h1234, 1'b1, 1'b1, "a_clr_wins");
    check("a_clr_wins_q", 64'(a_q), 64'h0000);
    drive(0, 1'b0, 1'b1, 32'h12F4, 1'b1, 1'b1, "a_clamp");
    check("a_clamp_q", 64'(a_q), 64'h1294);

    // Asynchronous reset between edges
    drive(0, 1'b0, 1'b1, 32'h0450, 1'b0, 1'b1, "a_load450");
    for (int i = 0; i < 7; i++) drive(0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, "a_to457");
    check("a_0457", 64'(a_q), 64'h0457);
    a_ena = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("a_async_rst", 64'({a_carry, a_sat, a_q}), 64'h0);
    for (int s = 0; s < 3; s++) begin m_cnt[s] = 0; m_sat[s] = 1'b0; end
    #2 rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, "a_after_rst");
    check("a_0001", 64'(a_q), 64'h0001);

    // Radix-6, 3-digit instance: one full revolution
    carries = 0;
    for (int i = 0; i < 216; i++) begin
      drive(2, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, "c_up");
      if (i == 6) check("c_after7", 64'(c_q), 64'({3'd0, 3'd1, 3'd1}));
    end
    check("c_back_to_0", 64'(c_q), 64'h0);
    check("c_one_carry", 64'(carries), 64'(1));
    drive(2, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "c_borrow");
    check("c_555", 64'({c_carry, c_q}), 64'({1'b1, 3'd5, 3'd5, 3'd5}));

    // Random mixed stimulus on every instance
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 300; i++) begin
        drive(s, ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0), $urandom,
              ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
